pc_gen_bp: RTL and testbench
============================

Name: pc_gen_bp

Overview:
Parametrised fetch-stage PC generator. It is the successor to the always-not-taken PC register and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Each cycle it predicts the next fetch PC from the current PC_F. It accepts a redirect from the resolve stage on mispredict and a BTB training port. It sits at the head of IF, driving the instruction-memory address and passing the prediction to the decode/execute stages.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_VEC, 32'h0000_0000, PC_F value after reset.
BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2.
IDX_W, $clog2(BTB_ENTRIES), index width (derived, not overridden).
TAG_W, XLEN-IDX_W-2, tag width (derived).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
stall_F  in  1  hold PC_F.
redirect_E  in  1  resolve stage mispredict; load redirect_pc_E.
redirect_pc_E  in  XLEN  correct next PC.
upd_valid  in  1  BTB training strobe (resolved branch/jump).
upd_pc  in  XLEN  PC of the resolved branch.
upd_taken  in  1  actual direction.
upd_target  in  XLEN  actual taken target.
PC_F  out  XLEN  current fetch PC (registered).
PC_plus4_F  out  XLEN  PC_F + 4 (combinational).
pred_taken_F  out  1  prediction for the instruction at PC_F.
pred_target_F  out  XLEN  predicted target (valid when pred_taken_F=1, else PC_F+4).

Behaviour:
- Reset (async, rst_n=0): PC_F=RESET_VEC; all BTB valid bits=0; all counters=2'b01 (weakly not-taken). Outputs follow, so pred_taken_F=0 and pred_target_F=RESET_VEC+4.
- Address split: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Lookup (combinational on PC_F and table state): hit = valid[idx] && tag[idx]==tag(PC_F). pred_taken_F = hit && ctr[idx][1]. pred_target_F = pred_taken_F ? tgt[idx] : PC_F+4.
- Next-PC priority at the clock edge:
  1. redirect_E: PC_F <= redirect_pc_E. This overrides stall_F.
  2. stall_F: PC_F holds.
  3. Otherwise: PC_F <= pred_target_F.
- All PC arithmetic is modulo 2^XLEN; PC_F+4 wraps from 0xFFFF_FFFC to 0.
- Training applies at the edge when upd_valid=1, independent of stall_F and redirect_E:
  - Hit on upd_pc, taken: ctr saturating +1 (max 2'b11); tgt <= upd_target.
  - Hit on upd_pc, not taken: ctr saturating -1 (min 2'b00); tgt unchanged.
  - Miss, taken: allocate/replace the entry: valid=1, tag, tgt=upd_target, ctr=2'b10.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents. The write becomes visible the next cycle. There is no bypass.
- Latency: prediction is 0-cycle relative to PC_F. The redirect takes effect on PC_F one edge later.
- Reset asserted mid-operation clears PC_F and the whole table immediately. No partial training survives.
- Storage is flops (no SRAM), which allows async reset of the valid bits and counters. The tgt and tag fields need no reset.

Test Plan:
- Reset and sequential fetch: rst_n low then high, no updates. PC_F goes 0x0, 0x4, 0x8, 0xC; pred_taken_F=0 throughout.
- Stall vs redirect: at PC_F=0x8, stall_F=1 for 3 cycles holds PC_F=0x8. Then stall_F=1 with redirect_E=1, redirect_pc_E=0x100: next PC_F=0x100.
- Allocate and predict: upd_valid with upd_pc=0x10, taken, target 0x40. When PC_F reaches 0x10: pred_taken_F=1, pred_target_F=0x40, next PC_F=0x40.
- Counter hysteresis: after allocation (ctr=10), one not-taken update gives ctr=01, so PC 0x10 predicts 0x14. Two taken updates give ctr=11. Three not-taken updates give 00, and a fourth stays saturated at 00.
- Tag alias: with BTB_ENTRIES=16, the entry for 0x10 is trained taken; fetch at 0x50 (same idx, different tag) gives pred_taken_F=0. Taken update at 0x50 with target 0x80 replaces the entry, after which 0x10 misses.
- Same-cycle update/lookup and wrap: update for 0x20 in the cycle PC_F=0x20 gives a miss that cycle and a hit on the next visit. With RESET_VEC=0xFFFF_FFFC, PC_F goes to 0x0 after one cycle.

Source files
------------

// File: rtl/pc_gen_bp_if.sv
// ----------------------------------------------------------------------------
// pc_gen_bp_if
// Bundle between the fetch PC generator and the rest of the pipeline.
//   stall_F        hold the current fetch PC
//   redirect_E     resolve-stage mispredict, load redirect_pc_E
//   redirect_pc_E  corrected next PC
//   upd_valid      BTB training strobe for a resolved branch/jump
//   upd_pc         PC of the resolved branch
//   upd_taken      resolved direction
//   upd_target     resolved taken target
//   PC_F           current fetch PC (registered)
//   PC_plus4_F     PC_F + 4
//   pred_taken_F   predicted direction for the instruction at PC_F
//   pred_target_F  predicted next PC (taken target, else PC_F + 4)
// Modports: master = PC generator side, slave = pipeline side.
// ----------------------------------------------------------------------------
interface pc_gen_bp_if #(
   parameter int XLEN = 32
);
   logic            stall_F;
   logic            redirect_E;
   logic [XLEN-1:0] redirect_pc_E;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic            upd_taken;
   logic [XLEN-1:0] upd_target;
   logic [XLEN-1:0] PC_F;
   logic [XLEN-1:0] PC_plus4_F;
   logic            pred_taken_F;
   logic [XLEN-1:0] pred_target_F;

   modport master (
      input  stall_F, redirect_E, redirect_pc_E,
      input  upd_valid, upd_pc, upd_taken, upd_target,
      output PC_F, PC_plus4_F, pred_taken_F, pred_target_F
   );

   modport slave (
      output stall_F, redirect_E, redirect_pc_E,
      output upd_valid, upd_pc, upd_taken, upd_target,
      input  PC_F, PC_plus4_F, pred_taken_F, pred_target_F
   );
endinterface

// File: rtl/pc_gen_bp.sv
// ----------------------------------------------------------------------------
// pc_gen_bp
// Fetch-stage PC generator with a direct-mapped branch target buffer and
// 2-bit saturating direction counters. The prediction is a pure
// combinational lookup on the registered PC_F; the next PC is chosen by
// redirect > stall > prediction.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pc_gen_bp_if.master (control inputs, training port, fetch outputs)
// ----------------------------------------------------------------------------
module pc_gen_bp #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = '0,
   parameter int              BTB_ENTRIES = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   pc_gen_bp_if.master  bus
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   // Table storage. valid/ctr carry reset; tag/tgt are only meaningful
   // once valid is set, so they are left unreset.
   logic             valid_reg [BTB_ENTRIES];
   logic [1:0]       ctr_reg   [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_reg   [BTB_ENTRIES];
   logic [XLEN-1:0]  tgt_reg   [BTB_ENTRIES];

   logic [XLEN-1:0]  pc_reg;
   logic [XLEN-1:0]  pc_next;
   logic [XLEN-1:0]  pc_plus4;

   // ---------------- lookup on the current fetch PC ----------------
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic             f_taken;
   logic [XLEN-1:0]  f_target;

   assign f_idx    = pc_reg[IDX_W+1:2];
   assign f_tag    = pc_reg[XLEN-1:IDX_W+2];
   assign pc_plus4 = pc_reg + XLEN'(4);   // wraps modulo 2^XLEN
   assign f_hit    = valid_reg[f_idx] && (tag_reg[f_idx] == f_tag);
   assign f_taken  = f_hit && ctr_reg[f_idx][1];
   assign f_target = f_taken ? tgt_reg[f_idx] : pc_plus4;

   assign bus.PC_F          = pc_reg;
   assign bus.PC_plus4_F    = pc_plus4;
   assign bus.pred_taken_F  = f_taken;
   assign bus.pred_target_F = f_target;

   // ---------------- next PC selection ----------------
   always_comb begin
      pc_next = f_target;
      if (bus.redirect_E) begin
         pc_next = bus.redirect_pc_E;
      end else if (bus.stall_F) begin
         pc_next = pc_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg <= RESET_VEC;
      end else begin
         pc_reg <= pc_next;
      end
   end

   // ---------------- training ----------------
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic [1:0]       ctr_next;

   assign u_idx = bus.upd_pc[IDX_W+1:2];
   assign u_tag = bus.upd_pc[XLEN-1:IDX_W+2];
   assign u_hit = valid_reg[u_idx] && (tag_reg[u_idx] == u_tag);

   // Saturating up/down counter for the entry being trained.
   always_comb begin
      ctr_next = ctr_reg[u_idx];
      if (bus.upd_taken) begin
         if (ctr_reg[u_idx] != 2'b11) begin
            ctr_next = ctr_reg[u_idx] + 2'b01;
         end
      end else begin
         if (ctr_reg[u_idx] != 2'b00) begin
            ctr_next = ctr_reg[u_idx] - 2'b01;
         end
      end
   end

   // Writes land at the edge, so a lookup in the same cycle still sees the
   // old contents; there is intentionally no bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_reg[i] <= 1'b0;
            ctr_reg[i]   <= 2'b01;
         end
      end else if (bus.upd_valid) begin
         if (u_hit) begin
            ctr_reg[u_idx] <= ctr_next;
         end else if (bus.upd_taken) begin
            valid_reg[u_idx] <= 1'b1;
            ctr_reg[u_idx]   <= 2'b10;
         end
      end
   end

   // Any taken update writes tag and target: on a hit the tag is unchanged,
   // on a miss this is the allocation/replacement.
   always_ff @(posedge clk) begin
      if (bus.upd_valid && bus.upd_taken) begin
         tag_reg[u_idx] <= u_tag;
         tgt_reg[u_idx] <= bus.upd_target;
      end
   end
endmodule

// File: tb/tb_pc_gen_bp.sv
// ----------------------------------------------------------------------------
// tb_pc_gen_bp
// Directed stimulus for pc_gen_bp. Each step drives one cycle of inputs and
// pushes the hand-computed outputs expected during that cycle; a monitor on
// the falling edge pops and compares. A second instance with
// RESET_VEC=0xFFFF_FFFC checks the PC wrap.
// ----------------------------------------------------------------------------
module tb_pc_gen_bp;
   logic clk;
   logic rst_n;

   pc_gen_bp_if #(.XLEN(32)) bus0 ();
   pc_gen_bp_if #(.XLEN(32)) bus1 ();

   pc_gen_bp #(.XLEN(32), .RESET_VEC(32'h0000_0000), .BTB_ENTRIES(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   pc_gen_bp #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .BTB_ENTRIES(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] tgt;
      logic        chk1;
      logic [31:0] pc1;
   } exp_t;

   exp_t  exp_q  [$];
   string name_q [$];
   int    checks   = 0;
   int    failures = 0;

   task automatic cmp(input string nm, input string fld,
                      input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s.%s got=%h exp=%h", nm, fld, got, want);
      end
   endtask

   // Monitor: outputs are stable mid-cycle; compare against queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         cmp(nm, "PC_F",          bus0.PC_F,          e.pc);
         cmp(nm, "PC_plus4_F",    bus0.PC_plus4_F,    e.pc + 32'd4);
         cmp(nm, "pred_taken_F",  {31'd0, bus0.pred_taken_F}, {31'd0, e.taken});
         cmp(nm, "pred_target_F", bus0.pred_target_F, e.tgt);
         if (e.chk1) begin
            cmp(nm, "wrap.PC_F",          bus1.PC_F,          e.pc1);
            cmp(nm, "wrap.pred_target_F", bus1.pred_target_F, e.pc1 + 32'd4);
         end
         $display("txn %-8s pc=%h taken=%b tgt=%h", nm, bus0.PC_F,
                  bus0.pred_taken_F, bus0.pred_target_F);
      end
   end

   // One cycle: drive inputs, queue expected outputs for this cycle, clock.
   task automatic step(input string nm,
                       input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt,
                       input logic [31:0] epc, input logic etk, input logic [31:0] etgt,
                       input logic chk1 = 1'b0, input logic [31:0] epc1 = 32'd0);
      exp_t e;
      bus0.stall_F       = stall;
      bus0.redirect_E    = redir;
      bus0.redirect_pc_E = rpc;
      bus0.upd_valid     = uv;
      bus0.upd_pc        = upc;
      bus0.upd_taken     = ut;
      bus0.upd_target    = utgt;
      e.pc = epc; e.taken = etk; e.tgt = etgt; e.chk1 = chk1; e.pc1 = epc1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      bus0.stall_F    = 1'b0;
      bus0.redirect_E = 1'b0;
      bus0.upd_valid  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus0.stall_F = 1'b0; bus0.redirect_E = 1'b0; bus0.redirect_pc_E = '0;
      bus0.upd_valid = 1'b0; bus0.upd_pc = '0; bus0.upd_taken = 1'b0;
      bus0.upd_target = '0;
      bus1.stall_F = 1'b0; bus1.redirect_E = 1'b0; bus1.redirect_pc_E = '0;
      bus1.upd_valid = 1'b0; bus1.upd_pc = '0; bus1.upd_taken = 1'b0;
      bus1.upd_target = '0;
      @(posedge clk);
      #1;
      //     name      stl rd rpc          uv upc          ut utgt         exp_pc       tk exp_tgt
      step("reset",    0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h0,       0, 32'h4, 1, 32'hFFFF_FFFC);
      rst_n = 1'b1;
      step("seq0",     0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h0,       0, 32'h4, 1, 32'hFFFF_FFFC);
      step("seq1",     0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h4,       0, 32'h8, 1, 32'h0);
      step("stall0",   1, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h8,       0, 32'hC, 1, 32'h4);
      step("stall1",   1, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h8,       0, 32'hC);
      step("stall2",   1, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h8,       0, 32'hC);
      step("stl_rd",   1, 1, 32'h100,     0, 32'h0,       0, 32'h0,       32'h8,       0, 32'hC);
      // allocate 0x10 -> 0x40 and steer fetch there
      step("alloc",    0, 1, 32'h10,      1, 32'h10,      1, 32'h40,      32'h100,     0, 32'h104);
      step("pred10",   0, 0, 32'h0,       1, 32'h10,      0, 32'h0,       32'h10,      1, 32'h40);
      step("at40",     0, 1, 32'h10,      0, 32'h0,       0, 32'h0,       32'h40,      0, 32'h44);
      step("ctr01",    0, 0, 32'h0,       1, 32'h10,      1, 32'h40,      32'h10,      0, 32'h14);
      step("at14",     0, 1, 32'h10,      1, 32'h10,      1, 32'h40,      32'h14,      0, 32'h18);
      step("ctr11",    1, 0, 32'h0,       1, 32'h10,      0, 32'h0,       32'h10,      1, 32'h40);
      step("ctr10",    1, 0, 32'h0,       1, 32'h10,      0, 32'h0,       32'h10,      1, 32'h40);
      step("ctr01b",   1, 0, 32'h0,       1, 32'h10,      0, 32'h0,       32'h10,      0, 32'h14);
      step("ctr00",    1, 0, 32'h0,       1, 32'h10,      0, 32'h0,       32'h10,      0, 32'h14);
      step("ctr00sat", 1, 0, 32'h0,       1, 32'h10,      1, 32'h40,      32'h10,      0, 32'h14);
      step("ctr01c",   1, 0, 32'h0,       1, 32'h10,      1, 32'h40,      32'h10,      0, 32'h14);
      step("ctr10b",   0, 1, 32'h50,      0, 32'h0,       0, 32'h0,       32'h10,      1, 32'h40);
      // tag alias on idx 4
      step("alias50",  0, 1, 32'h10,      1, 32'h50,      1, 32'h80,      32'h50,      0, 32'h54);
      step("evict10",  0, 1, 32'h50,      0, 32'h0,       0, 32'h0,       32'h10,      0, 32'h14);
      step("hit50",    0, 1, 32'h20,      0, 32'h0,       0, 32'h0,       32'h50,      1, 32'h80);
      // same-cycle update/lookup: miss now, hit on next visit
      step("same20",   0, 1, 32'h20,      1, 32'h20,      1, 32'h200,     32'h20,      0, 32'h24);
      step("hit20",    0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h20,      1, 32'h200);
      step("at200",    0, 0, 32'h0,       1, 32'h24,      0, 32'h0,       32'h200,     0, 32'h204);
      step("at204",    0, 1, 32'h24,      0, 32'h0,       0, 32'h0,       32'h204,     0, 32'h208);
      step("nt24",     0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h24,      0, 32'h28);
      // reset mid-operation clears PC and table
      rst_n = 1'b0;
      step("midrst",   0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h0,       0, 32'h4, 1, 32'hFFFF_FFFC);
      rst_n = 1'b1;
      step("post0",    0, 1, 32'h10,      0, 32'h0,       0, 32'h0,       32'h0,       0, 32'h4);
      step("post10",   0, 1, 32'h50,      0, 32'h0,       0, 32'h0,       32'h10,      0, 32'h14);
      step("post50",   0, 1, 32'h20,      0, 32'h0,       0, 32'h0,       32'h50,      0, 32'h54);
      step("post20",   0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h20,      0, 32'h24);

      // Drain: bounded wait for the monitor to consume everything queued.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
